// File: rtl/ssp_pkg.sv
// Shared SSP definitions: transmit FSM states, word-width limits and the parity
// helper used by both the transmit serializer and the receive-side checker.
package ssp_pkg;

    localparam int unsigned SSP_DATA_W_MIN = 4;
    localparam int unsigned SSP_DATA_W_MAX = 16;

    typedef enum logic [1:0] {
        SSP_TX_IDLE  = 2'd0,
        SSP_TX_FRAME = 2'd1,
        SSP_TX_SHIFT = 2'd2
    } ssp_tx_state_t;

    // Even parity over a word that is zero-extended to the maximum width.
    function automatic logic ssp_parity(input logic [SSP_DATA_W_MAX-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: TI synchronous serial frames, MSB first, one-cycle FSS.
// Define SSP_TX_PARITY_EN to append an even-parity bit after every word.
module ssp_tx_serializer
    import ssp_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_sync_reset,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic              o_ssp_txd,
    output logic              o_ssp_fss,
    output logic              o_ssp_oe,
    output logic              o_busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

    ssp_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] nxt_q, nxt_d;
    logic             nxt_vld_q, nxt_vld_d;
    logic             txd_q, txd_d;
    logic             fss_q, fss_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             accept_win;
    logic             end_of_word;
    logic             xfer;

`ifdef SSP_TX_PARITY_EN
    logic             par_q, par_d;

    // The parity cycle follows bit 0, so the accept window moves onto bit 0.
    assign accept_win  = (state_q == SSP_TX_SHIFT) && (cnt_q == '0) && !par_q;
    assign end_of_word = (state_q == SSP_TX_SHIFT) && par_q;
`else
    assign accept_win  = (state_q == SSP_TX_SHIFT) && (cnt_q == CNT_W'(1));
    assign end_of_word = (state_q == SSP_TX_SHIFT) && (cnt_q == '0);
`endif

    assign o_tx_ready = !i_sync_reset && ((state_q == SSP_TX_IDLE) || accept_win);
    assign xfer       = i_tx_valid && o_tx_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
`ifdef SSP_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            SSP_TX_IDLE: begin
                if (xfer) begin
                    sr_d    = i_tx_data;
                    state_d = SSP_TX_FRAME;
                end
            end
            SSP_TX_FRAME: begin
                state_d = SSP_TX_SHIFT;
                cnt_d   = CNT_TOP;
            end
            SSP_TX_SHIFT: begin
                if (xfer) begin
                    nxt_d     = i_tx_data;
                    nxt_vld_d = 1'b1;
                end
                if (end_of_word) begin
`ifdef SSP_TX_PARITY_EN
                    par_d = 1'b0;
`endif
                    if (nxt_vld_q) begin
                        sr_d      = nxt_q;
                        nxt_vld_d = 1'b0;
                        cnt_d     = CNT_TOP;
                    end else begin
                        state_d = SSP_TX_IDLE;
                        cnt_d   = '0;
                    end
`ifdef SSP_TX_PARITY_EN
                end else if (cnt_q == '0) begin
                    par_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = SSP_TX_IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins change on the edge that enters it.
    always_comb begin
        txd_d  = 1'b0;
        fss_d  = 1'b0;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            SSP_TX_FRAME: begin
                fss_d  = 1'b1;
                oe_d   = 1'b1;
                busy_d = 1'b1;
            end
            SSP_TX_SHIFT: begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
                txd_d  = sr_d[cnt_d];
`ifdef SSP_TX_PARITY_EN
                if (par_d) begin
                    txd_d = ssp_parity(SSP_DATA_W_MAX'(sr_d));
                end
                fss_d = nxt_vld_d && par_d;
`else
                fss_d = nxt_vld_d && (cnt_d == '0);
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_reset) begin
            state_q   <= SSP_TX_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            nxt_q     <= '0;
            nxt_vld_q <= 1'b0;
            txd_q     <= 1'b0;
            fss_q     <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SSP_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
            txd_q     <= txd_d;
            fss_q     <= fss_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
`ifdef SSP_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign o_ssp_txd = txd_q;
    assign o_ssp_fss = fss_q;
    assign o_ssp_oe  = oe_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer (DATA_W=8); the parity section is used
// only when SSP_TX_PARITY_EN is defined.
module tb_ssp_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       fss;
    logic       oe;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ssp_tx_serializer #(.DATA_W(8)) dut (
        .i_clk        (clk),
        .i_sync_reset (rst),
        .i_tx_data    (data),
        .i_tx_valid   (valid),
        .o_tx_ready   (ready),
        .o_ssp_txd    (txd),
        .o_ssp_fss    (fss),
        .o_ssp_oe     (oe),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_txd"},   {31'd0, txd},   32'd0);
        chk({tag, "_fss"},   {31'd0, fss},   32'd0);
        chk({tag, "_oe"},    {31'd0, oe},    32'd0);
        chk({tag, "_busy"},  {31'd0, busy},  32'd0);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_fss"},   {31'd0, fss},   32'd1);
        chk({tag, "_txd"},   {31'd0, txd},   32'd0);
        chk({tag, "_oe"},    {31'd0, oe},    32'd1);
        chk({tag, "_busy"},  {31'd0, busy},  32'd1);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    endtask

    // Shifts one word; vf >= 1 raises valid with nd at that bit index and drops it after bit 0 arrives.
    task automatic shift_word(input logic [7:0] w, input int vf, input logic [7:0] nd, input string tag);
        for (int i = 7; i >= 0; i--) begin
            cyc();
            if (i == 0 && vf >= 0) valid = 1'b0;
            chk($sformatf("%s_txd%0d", tag, i),   {31'd0, txd},   {31'd0, w[i]});
            chk($sformatf("%s_fss%0d", tag, i),   {31'd0, fss},   (i == 0 && vf >= 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s_oe%0d", tag, i),    {31'd0, oe},    32'd1);
            chk($sformatf("%s_busy%0d", tag, i),  {31'd0, busy},  32'd1);
            chk($sformatf("%s_ready%0d", tag, i), {31'd0, ready}, (i == 1) ? 32'd1 : 32'd0);
            if (i == vf) begin
                valid = 1'b1;
                data  = nd;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        cyc();
        cyc();
        chk("rst_txd",   {31'd0, txd},   32'd0);
        chk("rst_fss",   {31'd0, fss},   32'd0);
        chk("rst_oe",    {31'd0, oe},    32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);

        // valid during reset must not start a frame
        valid = 1'b1;
        data  = 8'hAA;
        cyc();
        chk("rstv_fss",  {31'd0, fss},  32'd0);
        chk("rstv_busy", {31'd0, busy}, 32'd0);
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        chk("rel_ready", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_idle($sformatf("idle%0d", i));
        end

`ifndef SSP_TX_PARITY_EN
        // isolated word 0xA5; data changes after accept must not leak in
        valid = 1'b1;
        data  = 8'hA5;
        cyc();
        valid = 1'b0;
        data  = 8'hFF;
        chk_frame("a5_frame");
        shift_word(8'hA5, -1, 8'h00, "a5");
        cyc();
        chk_idle("a5_end");

        // back-to-back 0x3C then 0xC3 with valid held high
        valid = 1'b1;
        data  = 8'h3C;
        cyc();
        data  = 8'hC3;
        chk_frame("s_frame");
        shift_word(8'h3C, 7, 8'hC3, "s3c");
        shift_word(8'hC3, -1, 8'h00, "sc3");
        cyc();
        chk_idle("s_end");

        // reset while bit 4 of 0xFF is on the wire
        valid = 1'b1;
        data  = 8'hFF;
        cyc();
        valid = 1'b0;
        chk_frame("ff_frame");
        for (int i = 7; i >= 4; i--) begin
            cyc();
            chk($sformatf("ff_txd%0d", i), {31'd0, txd}, 32'd1);
        end
        rst = 1'b1;
        cyc();
        chk("mr_txd",   {31'd0, txd},   32'd0);
        chk("mr_fss",   {31'd0, fss},   32'd0);
        chk("mr_oe",    {31'd0, oe},    32'd0);
        chk("mr_busy",  {31'd0, busy},  32'd0);
        chk("mr_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_rel_ready", {31'd0, ready}, 32'd1);
        valid = 1'b1;
        data  = 8'h01;
        cyc();
        valid = 1'b0;
        chk_frame("r01_frame");
        shift_word(8'h01, -1, 8'h00, "r01");
        cyc();
        chk_idle("r01_end");

        // valid raised at cnt=5 waits for the cnt==1 window
        valid = 1'b1;
        data  = 8'h96;
        cyc();
        valid = 1'b0;
        chk_frame("m96_frame");
        shift_word(8'h96, 5, 8'h5A, "m96");
        shift_word(8'h5A, -1, 8'h00, "m5a");
        cyc();
        chk_idle("m_end0");
        cyc();
        chk_idle("m_end1");
`else
        // word 0x07 followed by parity bit 1
        valid = 1'b1;
        data  = 8'h07;
        cyc();
        valid = 1'b0;
        chk_frame("p_frame");
        for (int i = 7; i >= 0; i--) begin
            cyc();
            chk($sformatf("p_txd%0d", i), {31'd0, txd}, (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("p_oe%0d", i),  {31'd0, oe},  32'd1);
            chk($sformatf("p_rdy%0d", i), {31'd0, ready}, (i == 0) ? 32'd1 : 32'd0);
        end
        cyc();
        chk("p_par",   {31'd0, txd},   32'd1);
        chk("p_fss",   {31'd0, fss},   32'd0);
        chk("p_oe",    {31'd0, oe},    32'd1);
        chk("p_ready", {31'd0, ready}, 32'd0);
        cyc();
        chk_idle("p_end");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
